// File: rtl/mem_bist_initiator.sv
`default_nettype none
// ============================================================================
// Module   : mem_bist_initiator
// Brief    : Valid/ready memory initiator that writes a seed-derived pattern
//            to every location, reads it back, and reports pass/fail,
//            mismatch count, first failing address and handshake timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bist_initiator #(
    parameter int WIDTH      = 2,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [WIDTH-1:0]      seed_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  wr_rd_o,
    output logic [WIDTH-1:0]      wr_data_o,
    output logic                  valid_o,
    input  logic [WIDTH-1:0]      rd_data_i,
    input  logic                  ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [ADDR_WIDTH:0]   err_cnt_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic                  timeout_o
);

    localparam int                    c_TW        = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [c_TW-1:0]       c_TMO_LAST  = c_TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WR_REQ = 3'd1,
        S_WR_GAP = 3'd2,
        S_RD_REQ = 3'd3,
        S_RD_GAP = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_addr, w_addr_nxt;
    logic [WIDTH-1:0]        r_seed, w_seed_nxt;
    logic [c_TW-1:0]         r_tcnt, w_tcnt_nxt;
    logic [ADDR_WIDTH:0]     r_err, w_err_nxt;
    logic [ADDR_WIDTH-1:0]   r_fail, w_fail_nxt;
    logic                    r_pass, w_pass_nxt;
    logic                    r_tmo, w_tmo_nxt;
    logic                    r_valid, r_wr_rd, r_busy, r_done;
    logic [WIDTH-1:0]        r_wdata;
    logic                    w_tmo_hit;
    logic                    w_wait_state;

    // Test pattern: address resized to the data width, XOR the seed.
    function automatic logic [WIDTH-1:0] f_pat(input logic [ADDR_WIDTH-1:0] a,
                                               input logic [WIDTH-1:0]      s);
        return WIDTH'(a) ^ s;
    endfunction

    // Next-state, result bookkeeping and timeout counter.
    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_addr;
        w_seed_nxt   = r_seed;
        w_err_nxt    = r_err;
        w_fail_nxt   = r_fail;
        w_pass_nxt   = r_pass;
        w_tmo_nxt    = r_tmo;
        w_tcnt_nxt   = '0;
        w_tmo_hit    = (r_tcnt == c_TMO_LAST);
        w_wait_state = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_seed_nxt  = seed_i;
                    w_err_nxt   = '0;
                    w_fail_nxt  = '0;
                    w_pass_nxt  = 1'b0;
                    w_tmo_nxt   = 1'b0;
                    w_addr_nxt  = '0;
                    w_state_nxt = S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                w_wait_state = 1'b1;
                if (ready_i) begin
                    w_state_nxt = S_WR_GAP;
                end else if (w_tmo_hit) begin
                    w_tmo_nxt   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_WR_GAP: begin
                w_wait_state = 1'b1;
                if (!ready_i) begin
                    if (r_addr == c_LAST_ADDR) begin
                        w_addr_nxt  = '0;
                        w_state_nxt = S_RD_REQ;
                    end else begin
                        w_addr_nxt  = r_addr + 1'b1;
                        w_state_nxt = S_WR_REQ;
                    end
                end else if (w_tmo_hit) begin
                    w_tmo_nxt   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_RD_REQ: begin
                w_wait_state = 1'b1;
                if (ready_i) begin
                    if (rd_data_i != f_pat(r_addr, r_seed)) begin
                        if (r_err == '0) begin
                            w_fail_nxt = r_addr;
                        end
                        if (r_err != '1) begin
                            w_err_nxt = r_err + 1'b1;
                        end
                    end
                    w_state_nxt = S_RD_GAP;
                end else if (w_tmo_hit) begin
                    w_tmo_nxt   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_RD_GAP: begin
                w_wait_state = 1'b1;
                if (!ready_i) begin
                    if (r_addr == c_LAST_ADDR) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_addr_nxt  = r_addr + 1'b1;
                        w_state_nxt = S_RD_REQ;
                    end
                end else if (w_tmo_hit) begin
                    w_tmo_nxt   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // Verdict is resolved on DONE entry so it is valid alongside done_o.
        if (w_state_nxt == S_DONE) begin
            w_pass_nxt = (w_err_nxt == '0) && !w_tmo_nxt;
        end
        // Counter restarts on every state change, counts only while waiting.
        if (w_wait_state && (w_state_nxt == r_state)) begin
            w_tcnt_nxt = r_tcnt + 1'b1;
        end
    end

    // State, bookkeeping and registered request/status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_seed  <= '0;
            r_tcnt  <= '0;
            r_err   <= '0;
            r_fail  <= '0;
            r_pass  <= 1'b0;
            r_tmo   <= 1'b0;
            r_valid <= 1'b0;
            r_wr_rd <= 1'b0;
            r_wdata <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_seed  <= w_seed_nxt;
            r_tcnt  <= w_tcnt_nxt;
            r_err   <= w_err_nxt;
            r_fail  <= w_fail_nxt;
            r_pass  <= w_pass_nxt;
            r_tmo   <= w_tmo_nxt;
            r_valid <= (w_state_nxt == S_WR_REQ) || (w_state_nxt == S_RD_REQ);
            r_wr_rd <= (w_state_nxt == S_WR_REQ);
            r_wdata <= (w_state_nxt == S_WR_REQ) ? f_pat(w_addr_nxt, w_seed_nxt) : '0;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    assign addr_o      = r_addr;
    assign wr_rd_o     = r_wr_rd;
    assign wr_data_o   = r_wdata;
    assign valid_o     = r_valid;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign pass_o      = r_pass;
    assign err_cnt_o   = r_err;
    assign fail_addr_o = r_fail;
    assign timeout_o   = r_tmo;

endmodule
`default_nettype wire

// File: tb/tb_mem_bist_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bist_initiator
// Brief    : Self-checking bench for mem_bist_initiator with a behavioural
//            registered-ready memory responder and several fault modes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bist_initiator;

    localparam int WIDTH      = 2;
    localparam int DEPTH      = 8;
    localparam int ADDR_WIDTH = 3;
    localparam int TIMEOUT    = 15;

    localparam int M_GOOD  = 0;  // correct memory
    localparam int M_ZERO  = 1;  // reads always return 0
    localparam int M_RDY0  = 2;  // ready stuck low
    localparam int M_RDY1  = 3;  // ready stuck high
    localparam int M_CORR5 = 4;  // bit 0 flipped when reading address 5

    typedef struct {
        int         mode;
        logic [1:0] seed;
        bit         restart;   // extra start pulse while busy
        bit         sdone;     // start pulse in the DONE cycle
        bit         wlog;      // check write sequence (seed 1 only)
        int         e_err;
        int         e_fail;
        int         e_pass;
        int         e_tmo;
        int         e_vcyc;    // cycles with valid_o high
        int         e_addr;    // addr_o at done
    } vec_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start_i = 1'b0;
    logic [WIDTH-1:0]      seed_i = '0;
    logic [ADDR_WIDTH-1:0] addr_o;
    logic                  wr_rd_o;
    logic [WIDTH-1:0]      wr_data_o;
    logic                  valid_o;
    logic [WIDTH-1:0]      rd_data_i;
    logic                  ready_i;
    logic                  busy_o;
    logic                  done_o;
    logic                  pass_o;
    logic [ADDR_WIDTH:0]   err_cnt_o;
    logic [ADDR_WIDTH-1:0] fail_addr_o;
    logic                  timeout_o;

    int mode = M_GOOD;
    int errs = 0;
    int checks = 0;
    int exp_wr[8] = '{1, 0, 3, 2, 1, 0, 3, 2};

    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic             r_rdy;
    logic [WIDTH-1:0] r_rdata;
    logic [4:0]       wlog[$];
    vec_t             vecs[8];

    always #5 clk = ~clk;

    mem_bist_initiator #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .seed_i(seed_i),
        .addr_o(addr_o), .wr_rd_o(wr_rd_o), .wr_data_o(wr_data_o),
        .valid_o(valid_o), .rd_data_i(rd_data_i), .ready_i(ready_i),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
        .err_cnt_o(err_cnt_o), .fail_addr_o(fail_addr_o), .timeout_o(timeout_o)
    );

    // Registered-ready memory: acknowledges one cycle after valid, then drops.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdy   <= 1'b0;
            r_rdata <= '0;
        end else if (valid_o && !r_rdy) begin
            r_rdy <= 1'b1;
            if (wr_rd_o) begin
                mem[addr_o] <= wr_data_o;
                wlog.push_back({addr_o, wr_data_o});
            end else if (mode == M_ZERO) begin
                r_rdata <= '0;
            end else if (mode == M_CORR5 && addr_o == 3'd5) begin
                r_rdata <= mem[addr_o] ^ 2'b01;
            end else begin
                r_rdata <= mem[addr_o];
            end
        end else begin
            r_rdy <= 1'b0;
        end
    end

    assign rd_data_i = r_rdata;
    assign ready_i   = (mode == M_RDY0) ? 1'b0 : (mode == M_RDY1) ? 1'b1 : r_rdy;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run(input int idx, input vec_t v);
        int cyc;
        int vcyc;
        bit busy_ok;
        mode   = v.mode;
        seed_i = v.seed;
        wlog.delete();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        seed_i  = ~v.seed;
        check($sformatf("r%0d_acc_busy", idx), busy_o, 1);
        check($sformatf("r%0d_acc_err", idx), err_cnt_o, 0);
        check($sformatf("r%0d_acc_tmo", idx), timeout_o, 0);
        check($sformatf("r%0d_acc_pass", idx), pass_o, 0);
        cyc = 0;
        vcyc = 0;
        busy_ok = 1'b1;
        while (!done_o && cyc < 300) begin
            if (valid_o) vcyc++;
            if (!busy_o) busy_ok = 1'b0;
            start_i = (v.restart && cyc == 20);
            @(negedge clk);
            cyc++;
        end
        start_i = 1'b0;
        check($sformatf("r%0d_done_seen", idx), done_o, 1);
        check($sformatf("r%0d_busy_held", idx), busy_ok, 1);
        check($sformatf("r%0d_vcyc", idx), vcyc, v.e_vcyc);
        check($sformatf("r%0d_pass", idx), pass_o, v.e_pass);
        check($sformatf("r%0d_err", idx), err_cnt_o, v.e_err);
        check($sformatf("r%0d_fail", idx), fail_addr_o, v.e_fail);
        check($sformatf("r%0d_tmo", idx), timeout_o, v.e_tmo);
        check($sformatf("r%0d_addr", idx), addr_o, v.e_addr);
        if (v.sdone) start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check($sformatf("r%0d_done_pulse", idx), done_o, 0);
        @(negedge clk);
        check($sformatf("r%0d_idle_busy", idx), busy_o, 0);
        check($sformatf("r%0d_pass_hold", idx), pass_o, v.e_pass);
        if (v.wlog) begin
            check($sformatf("r%0d_wcnt", idx), wlog.size(), 8);
            for (int i = 0; i < 8 && i < wlog.size(); i++) begin
                check($sformatf("r%0d_waddr%0d", idx, i), wlog[i][4:2], i);
                check($sformatf("r%0d_wdata%0d", idx, i), wlog[i][1:0], exp_wr[i]);
            end
        end
    endtask

    initial begin
        bit found;
        bit dseen;
        vecs[0] = '{M_GOOD,  2'd1, 1'b0, 1'b0, 1'b1, 0, 0, 1, 0, 32, 7};
        vecs[1] = '{M_ZERO,  2'd0, 1'b0, 1'b0, 1'b0, 6, 1, 0, 0, 32, 7};
        vecs[2] = '{M_RDY0,  2'd2, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1, 15, 0};
        vecs[3] = '{M_RDY1,  2'd0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1,  1, 0};
        vecs[4] = '{M_GOOD,  2'd1, 1'b1, 1'b0, 1'b1, 0, 0, 1, 0, 32, 7};
        vecs[5] = '{M_ZERO,  2'd3, 1'b0, 1'b0, 1'b0, 6, 0, 0, 0, 32, 7};
        vecs[6] = '{M_CORR5, 2'd1, 1'b0, 1'b0, 1'b0, 1, 5, 0, 0, 32, 7};
        vecs[7] = '{M_GOOD,  2'd2, 1'b0, 1'b1, 1'b0, 0, 0, 1, 0, 32, 7};

        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_pass", pass_o, 0);
        check("rst_err", err_cnt_o, 0);
        check("rst_addr", addr_o, 0);
        check("rst_tmo", timeout_o, 0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run(i, vecs[i]);

        // Asynchronous reset in the middle of the read phase.
        mode   = M_GOOD;
        seed_i = 2'd1;
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            if (valid_o && !wr_rd_o && addr_o == 3'd4) found = 1'b1;
            else @(negedge clk);
        end
        check("mr_reach_rd4", found, 1);
        #2 rst = 1'b0;
        #1;
        check("mr_valid", valid_o, 0);
        check("mr_busy", busy_o, 0);
        check("mr_addr", addr_o, 0);
        check("mr_wr_rd", wr_rd_o, 0);
        check("mr_wdata", wr_data_o, 0);
        check("mr_outs", {done_o, pass_o, err_cnt_o, fail_addr_o, timeout_o}, 0);
        dseen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done_o) dseen = 1'b1;
        end
        check("mr_no_done", dseen, 0);
        rst = 1'b1;
        @(negedge clk);
        run(8, '{M_GOOD, 2'd3, 1'b0, 1'b0, 1'b0, 0, 0, 1, 0, 32, 7});

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_bist_initiator.md
Name: mem_bist_initiator

Overview:
- Initiator (master) side of the team's single-port valid/ready memory interface: addr, wr_rd, wr_data, valid out; rd_data, ready in.
- On a start pulse it runs a self-check:
  - writes a seed-derived pattern to every location 0..DEPTH-1;
  - reads every location back and compares.
- Reports pass/fail, mismatch count, first failing address and handshake timeout.
- Sits between the memory model and test/control logic; used for bring-up and as a traffic source for memory verification.

Parameters:
- WIDTH, 2, data width; must match the memory.
- DEPTH, 8, number of locations exercised (addresses 0..DEPTH-1).
- ADDR_WIDTH, 3, address width; DEPTH <= 2**ADDR_WIDTH.
- TIMEOUT, 15, maximum cycles spent in any one request or gap state before abort; TIMEOUT >= 2.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets immediately; release is synchronous to clk).
- start_i  input  1  pulse to begin a test; ignored while busy_o=1.
- seed_i  input  WIDTH  pattern seed; captured when start_i is accepted.
- addr_o  output  ADDR_WIDTH  memory address.
- wr_rd_o  output  1  1=write, 0=read.
- wr_data_o  output  WIDTH  write data.
- valid_o  output  1  request valid.
- rd_data_i  input  WIDTH  read data from memory.
- ready_i  input  1  memory ready/acknowledge.
- busy_o  output  1  test in progress.
- done_o  output  1  one-cycle pulse at test end.
- pass_o  output  1  1 = last test had zero mismatches and no timeout; held until next start.
- err_cnt_o  output  ADDR_WIDTH+1  mismatch count of last test; saturates at all-ones.
- fail_addr_o  output  ADDR_WIDTH  address of first mismatch; 0 if none.
- timeout_o  output  1  last test aborted on handshake timeout; held until next start.

Behaviour:
- Reset (rst=0, async):
  - all outputs 0;
  - FSM to IDLE;
  - address and timeout counters 0.
- Pattern: P(a) = (a zero-extended or truncated to WIDTH) XOR seed.
- FSM states:
  - IDLE: busy_o=0, valid_o=0. On start_i=1:
    - capture seed;
    - clear err_cnt_o, fail_addr_o, pass_o, timeout_o;
    - set addr=0;
    - go to WR_REQ.
  - WR_REQ: valid_o=1, wr_rd_o=1, addr_o=addr, wr_data_o=P(addr). These values are held stable until ready_i=1 is sampled; then go to WR_GAP.
  - WR_GAP: valid_o=0. Wait until ready_i=0 is sampled, so a stale ready is never taken as the next acknowledge. Then:
    - if addr==DEPTH-1: addr=0, go to RD_REQ;
    - otherwise: addr+1, go to WR_REQ.
  - RD_REQ: valid_o=1, wr_rd_o=0, addr_o=addr, wr_data_o=0. On the edge where ready_i=1 is sampled:
    - compare rd_data_i with P(addr);
    - on mismatch: increment err_cnt_o (saturating); if this is the first mismatch, load fail_addr_o=addr;
    - go to RD_GAP.
  - RD_GAP: valid_o=0. Wait for ready_i=0. Then:
    - if addr==DEPTH-1: go to DONE;
    - otherwise: addr+1, go to RD_REQ.
  - DONE (one cycle):
    - done_o=1;
    - pass_o = (err_cnt_o==0) && !timeout_o;
    - then IDLE.
- Timing: minimum 2 cycles per transaction with a registered-ready responder. All request outputs are registered.
- Timeout:
  - a counter clears on every state entry and increments each cycle spent in WR_REQ, WR_GAP, RD_REQ or RD_GAP;
  - on reaching TIMEOUT: set timeout_o=1, drop valid_o the same edge, go to DONE (pass_o=0).
- Simultaneous events:
  - start_i while busy: ignored;
  - start_i in the DONE cycle: ignored;
  - ready_i=1 on the entry cycle of a REQ state counts as acknowledge.
- Reset mid-test: aborts immediately; valid_o drops asynchronously; no done_o pulse.
- Last-location wrap: addr never exceeds DEPTH-1; addr returns to 0 when switching from write to read.

Test Plan:
- Connected to a correct memory (defaults), seed=2'b01, start pulse:
  - writes data 1,0,3,2,1,0,3,2 to addresses 0..7 in order;
  - reads all 8 back;
  - done_o pulses once; pass_o=1, err_cnt_o=0, timeout_o=0; busy_o high throughout.
- Fault memory stub returning rd_data=0 for reads, seed=0:
  - mismatches on addresses 1,2,3,5,6,7 (P=1,2,3,1,2,3);
  - err_cnt_o=6, fail_addr_o=1, pass_o=0.
- Stub holding ready_i=0 permanently: valid_o stays 1 for exactly 15 cycles in WR_REQ at addr 0, then drops; done_o pulses; timeout_o=1, pass_o=0.
- Stub holding ready_i=1 permanently:
  - first write acknowledged;
  - WR_GAP never sees ready_i=0, so timeout after 15 cycles with addr_o=0;
  - timeout_o=1.
- Assert rst=0 asynchronously during the read phase at addr 4: valid_o, busy_o and every other output go to 0 before the next edge, with no done_o pulse. After release, a start with seed=3 completes with pass_o=1.
- A second start_i while busy_o=1: no effect on sequence or results. A start after done_o: err_cnt_o and timeout_o clear in the acceptance cycle.
